// File: rtl/noc_dest_demux_if.sv
// Packet handshake bundle between the merge tree, the destination demux and
// the four destination consumers.
interface noc_dest_demux_if #(
    parameter int WIDTH = 33
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [3:0]       out_valid;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_ready;

    // Producer/consumer side: drives packets in and readies out.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    // Demux side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/noc_dest_demux.sv
// Buffers the merged packet stream in a small FIFO and steers the head packet
// to one of four ports by its 2-bit destination field; keeps per-port counts.
module noc_dest_demux #(
    parameter int WIDTH    = 33,
    parameter int DEPTH    = 4,   // power of 2, at least 2
    parameter int DEST_LSB = 31,
    parameter int CNT_W    = 16,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int OCC_W   = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    noc_dest_demux_if.slave    bus,
    output logic [OCC_W-1:0]   occupancy,
    output logic [4*CNT_W-1:0] pkt_cnt
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic [WIDTH-1:0] head;
    logic [1:0]       dest;
    logic             not_empty;
    logic             push;
    logic             pop;

    assign head      = mem_q[rd_ptr_q];
    assign dest      = head[DEST_LSB +: 2];
    assign not_empty = (occ_q != '0);

    // Handshake decode uses registered state only: no in-to-out bypass and
    // in_ready never looks at out_ready.
    always_comb begin
        bus.in_ready  = (occ_q < OCC_W'(DEPTH));
        bus.out_valid = not_empty ? (4'b0001 << dest) : 4'b0000;
        bus.out_data  = head;
        push          = bus.in_valid && bus.in_ready;
        pop           = not_empty && bus.out_ready[dest];
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        // Saturating count of deliveries to the popped port.
        if (pop && (cnt_q[dest] != '1)) begin
            cnt_d[dest] = cnt_q[dest] + CNT_W'(1);
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
        occupancy = occ_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Storage needs no reset: entries are only visible while occupancy covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_noc_dest_demux.sv
// Randomised and directed bench for noc_dest_demux, checked against a
// queue-based reference model; a second instance with 2-bit counters shares the stimulus.
module tb_noc_dest_demux;

    localparam int WIDTH    = 33;
    localparam int DEPTH    = 4;
    localparam int DEST_LSB = 31;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    noc_dest_demux_if #(.WIDTH(WIDTH)) bus ();
    noc_dest_demux_if #(.WIDTH(WIDTH)) bus2 ();

    logic [2:0]  occupancy;
    logic [63:0] pkt_cnt;
    logic [2:0]  occupancy2;
    logic [7:0]  pkt_cnt2;

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_data   = bus.in_data;
    assign bus2.out_ready = bus.out_ready;

    noc_dest_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEST_LSB(DEST_LSB), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .occupancy (occupancy),
        .pkt_cnt   (pkt_cnt)
    );

    noc_dest_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEST_LSB(DEST_LSB), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2.slave),
        .occupancy (occupancy2),
        .pkt_cnt   (pkt_cnt2)
    );

    // Reference model: FIFO contents as a queue, delivered counts as integers.
    logic [WIDTH-1:0] mq[$];
    int unsigned      cnt_ref [4];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk(input logic [1:0] d, input logic [30:0] p);
        return {d, p};
    endfunction

    function automatic logic [1:0] head_dest();
        logic [WIDTH-1:0] h;
        h = mq[0];
        return h[DEST_LSB +: 2];
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 4; i++) cnt_ref[i] = 0;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_valid;
        exp_valid = (mq.size() != 0) ? (4'b0001 << head_dest()) : 4'b0000;
        check("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        if (mq.size() != 0) check("out_data", 64'(bus.out_data), 64'(mq[0]));
        check("occupancy", 64'(occupancy), 64'(mq.size()));
        check("sat_out_valid", 64'(bus2.out_valid), 64'(exp_valid));
        check("sat_occupancy", 64'(occupancy2), 64'(mq.size()));
        for (int d = 0; d < 4; d++) begin
            check($sformatf("pkt_cnt%0d", d), 64'(pkt_cnt[d*16 +: 16]),
                  64'((cnt_ref[d] > 65535) ? 65535 : cnt_ref[d]));
            check($sformatf("sat_pkt_cnt%0d", d), 64'(pkt_cnt2[d*2 +: 2]),
                  64'((cnt_ref[d] > 3) ? 3 : cnt_ref[d]));
        end
    endtask

    // One clock: check at the falling edge, then advance the model with the
    // handshakes seen at the rising edge; returns #1 after that edge.
    task automatic cycle();
        bit         do_push, do_pop;
        logic [1:0] d;
        @(negedge clk);
        check_outputs();
        do_push = bus.in_valid && (mq.size() < DEPTH);
        do_pop  = 1'b0;
        d       = 2'd0;
        if (mq.size() != 0) begin
            d      = head_dest();
            do_pop = bus.out_ready[d];
        end
        @(posedge clk);
        if (do_pop) begin
            void'(mq.pop_front());
            cnt_ref[d]++;
        end
        if (do_push) mq.push_back(bus.in_data);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 3 * DEPTH && mq.size() != 0; i++) cycle();
        check("drained", 64'(occupancy), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom);
            bus.in_data   = mk(2'($urandom), 31'($urandom));
            bus.out_ready = 4'($urandom);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        rst_n = 1'b1;
    endtask

    logic [WIDTH-1:0] pkts [4];
    logic [3:0]       seq  [4];
    logic [63:0]      rnd;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;

        // Reset with random inputs, then idle state.
        apply_reset();
        cycle();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_pkt_cnt", pkt_cnt, 64'd0);

        // Single packet: bit 31 set, so the destination field is 2'b01.
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        bus.in_data   = 33'h0_8000_0005;
        cycle();
        bus.in_valid = 1'b0;
        check("single_valid", 64'(bus.out_valid), 64'h2);
        check("single_data", 64'(bus.out_data), 64'h0_8000_0005);
        cycle();
        check("single_cnt1", 64'(pkt_cnt[31:16]), 64'd1);
        check("single_empty", 64'(bus.out_valid), 64'd0);

        // Steering and order: back-to-back pushes, all ports ready.
        pkts[0] = mk(2'd3, 31'h11); seq[0] = 4'b1000;
        pkts[1] = mk(2'd1, 31'h22); seq[1] = 4'b0010;
        pkts[2] = mk(2'd2, 31'h33); seq[2] = 4'b0100;
        pkts[3] = mk(2'd0, 31'h44); seq[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = pkts[i];
            cycle();
            check("steer_valid", 64'(bus.out_valid), 64'(seq[i]));
            check("steer_data", 64'(bus.out_data), 64'(pkts[i]));
        end
        bus.in_valid = 1'b0;
        cycle();
        check("steer_cnt", pkt_cnt, {16'd1, 16'd1, 16'd2, 16'd1});

        // Full and backpressure.
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = mk(2'($urandom), 31'($urandom));
            cycle();
            if (i == 3) begin
                check("full_in_ready", 64'(bus.in_ready), 64'd0);
                check("full_occ", 64'(occupancy), 64'd4);
            end
        end
        check("full_held_occ", 64'(occupancy), 64'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0001 << head_dest();
        cycle();
        check("bp_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_occ", 64'(occupancy), 64'd3);
        for (int i = 0; i < 8 && mq.size() != 0; i++) begin
            bus.out_ready = 4'b0001 << head_dest();
            cycle();
        end
        check("bp_empty", 64'(occupancy), 64'd0);

        // Head-of-line blocking.
        bus.out_ready = 4'b1011;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk(2'd2, 31'h0ABC);
        cycle();
        bus.in_data   = mk(2'd0, 31'h0DEF);
        cycle();
        bus.in_valid  = 1'b0;
        repeat (3) cycle();
        check("hol_valid", 64'(bus.out_valid), 64'h4);
        check("hol_data", 64'(bus.out_data), 64'(mk(2'd2, 31'h0ABC)));
        check("hol_occ", 64'(occupancy), 64'd2);
        bus.out_ready = 4'b0100;
        cycle();
        check("hol_release_valid", 64'(bus.out_valid), 64'h1);
        check("hol_release_data", 64'(bus.out_data), 64'(mk(2'd0, 31'h0DEF)));
        drain();

        // Mid-operation asynchronous reset with three packets buffered.
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = mk(2'($urandom), 31'($urandom));
            cycle();
        end
        bus.in_valid = 1'b0;
        check("mid_occ3", 64'(occupancy), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_occ", 64'(occupancy), 64'd0);
        check("async_valid", 64'(bus.out_valid), 64'd0);
        check("async_in_ready", 64'(bus.in_ready), 64'd1);
        check("async_cnt", pkt_cnt, 64'd0);
        check("async_sat_cnt", 64'(pkt_cnt2), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();

        // Counter saturation: five deliveries to port 1.
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = mk(2'd1, 31'(i));
            cycle();
        end
        drain();
        check("sat_port1", 64'(pkt_cnt2[3:2]), 64'd3);
        check("wide_port1", 64'(pkt_cnt[31:16]), 64'd5);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rnd           = {$urandom, $urandom};
            bus.in_valid  = ($urandom_range(3, 0) != 0);
            bus.in_data   = rnd[WIDTH-1:0];
            bus.out_ready = 4'($urandom);
            if ($urandom_range(7, 0) == 0) bus.out_ready = 4'b0000;
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
